// File: rtl/regfile_rr_ctrl_if.sv
// Requester-side bus of the shared register-file controller: two request
// channels in, per-requester ack pulse and last read result out.
interface regfile_rr_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  logic          req0;
  logic          req1;
  logic          wr0;
  logic          wr1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata0, rdata1
  );

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata0, rdata1
  );
endinterface

// File: rtl/regfile_rr_ctrl.sv
// Round-robin controller sharing one register file (one write port, one read
// port) between two requesters; all outputs are registered.
module regfile_rr_ctrl #(
  parameter int DW     = 32,
  parameter int AW     = 4,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_rr_ctrl_if.slave      bus,
  output logic                  busy,
  output logic                  rf_write_en,
  output logic [AW-1:0]         rf_write_line,
  output logic [DW-1:0]         rf_data_in,
  output logic                  rf_read_en,
  output logic [AW-1:0]         rf_read_line,
  input  logic [DW-1:0]         rf_data_out
);

  typedef enum logic [2:0] {IDLE, WR, RD, WAIT, ACK} state_t;

  state_t     state;
  logic       prio;   // requester that wins the next tie
  logic       win;
  logic [1:0] cnt;
  logic       pick;

  // NOTE: pick gets its default before the if-chain so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pick = prio;
    if (bus.req0 && !bus.req1)      pick = 1'b0;
    else if (bus.req1 && !bus.req0) pick = 1'b1;
  end

  // NOTE: every state register below uses non-blocking assignments so all
  // of them update together from the values sampled at the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      prio          <= 1'b0;
      win           <= 1'b0;
      cnt           <= '0;
      busy          <= 1'b0;
      rf_write_en   <= 1'b0;
      rf_write_line <= '0;
      rf_data_in    <= '0;
      rf_read_en    <= 1'b0;
      rf_read_line  <= '0;
      bus.ack0      <= 1'b0;
      bus.ack1      <= 1'b0;
      bus.rdata0    <= '0;
      bus.rdata1    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            win  <= pick;
            prio <= ~pick;
            busy <= 1'b1;
            // The rf line/data registers double as the latched request fields.
            if (pick ? bus.wr1 : bus.wr0) begin
              state         <= WR;
              rf_write_en   <= 1'b1;
              rf_write_line <= pick ? bus.addr1 : bus.addr0;
              rf_data_in    <= pick ? bus.wdata1 : bus.wdata0;
            end else begin
              state        <= RD;
              rf_read_en   <= 1'b1;
              rf_read_line <= pick ? bus.addr1 : bus.addr0;
            end
          end
        end
        WR: begin
          rf_write_en <= 1'b0;
          bus.ack0    <= ~win;
          bus.ack1    <= win;
          state       <= ACK;
        end
        RD: begin
          rf_read_en <= 1'b0;
          cnt        <= 2'(RD_LAT - 1);
          state      <= WAIT;
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            if (win) bus.rdata1 <= rf_data_out;
            else     bus.rdata0 <= rf_data_out;
            bus.ack0 <= ~win;
            bus.ack1 <= win;
            state    <= ACK;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        ACK: begin
          bus.ack0 <= 1'b0;
          bus.ack1 <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
